// File: rtl/mdu_seq_pkg.sv
// mdu_seq_pkg: op codes, ALU control codes, FSM states and decode helpers
// for the iterative RV32M multiply/divide sequencer.
package mdu_seq_pkg;

    // funct3 encodings of the RV32M instructions
    typedef enum logic [2:0] {
        MDU_MUL    = 3'b000,
        MDU_MULH   = 3'b001,
        MDU_MULHSU = 3'b010,
        MDU_MULHU  = 3'b011,
        MDU_DIV    = 3'b100,
        MDU_DIVU   = 3'b101,
        MDU_REM    = 3'b110,
        MDU_REMU   = 3'b111
    } mdu_op_e;

    // The shared ALU decoder uses these same control codes
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;

    // Every op walks through every state, which keeps the latency fixed
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_NEG_A  = 3'd1,
        ST_NEG_B  = 3'd2,
        ST_ITER   = 3'd3,
        ST_FIX_LO = 3'd4,
        ST_FIX_HI = 3'd5,
        ST_DONE   = 3'd6
    } mdu_state_e;

    // Divide and remainder ops share the restoring datapath
    function automatic logic op_is_div(input mdu_op_e op);
        return (op == MDU_DIV) || (op == MDU_DIVU) ||
               (op == MDU_REM) || (op == MDU_REMU);
    endfunction

    // Ops that treat rs1 as two's complement
    function automatic logic op_signed_a(input mdu_op_e op);
        return (op == MDU_MULH) || (op == MDU_MULHSU) ||
               (op == MDU_DIV)  || (op == MDU_REM);
    endfunction

    // Ops that treat rs2 as two's complement (MULHSU keeps rs2 unsigned)
    function automatic logic op_signed_b(input mdu_op_e op);
        return (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
    endfunction

endpackage

// File: rtl/mdu_seq_if.sv
// mdu_seq_if: pipeline handshake plus the borrowed-ALU port of the
// multiply/divide sequencer. The sequencer is the slave; the EX stage
// (request side and shared ALU) is the master.
interface mdu_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             flush;
    logic [2:0]       op;
    logic [WIDTH-1:0] rs1;
    logic [WIDTH-1:0] rs2;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             alu_sel;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_ctrl;
    logic [WIDTH-1:0] alu_out;

    modport master (
        output start, flush, op, rs1, rs2, alu_out,
        input  busy, done, result, alu_sel, alu_a, alu_b, alu_ctrl
    );

    modport slave (
        input  start, flush, op, rs1, rs2, alu_out,
        output busy, done, result, alu_sel, alu_a, alu_b, alu_ctrl
    );

endinterface

// File: rtl/mdu_seq.sv
// mdu_seq: iterative RV32M multiply/divide sequencer. All adds/subtracts
// go through the shared EX-stage ALU; shifts and compares are local.
// Multiply is shift-add on {hi,lo}, divide is restoring on {hi=rem,lo=quo};
// operands are made positive up front and the sign is fixed at the end.
module mdu_seq
    import mdu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      reset,
    mdu_seq_if.slave  bus
);

    localparam int               CNT_W     = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

    mdu_state_e       state;
    mdu_state_e       state_next;
    logic [CNT_W-1:0] cnt;
    mdu_op_e          op_q;
    logic [WIDTH-1:0] rs1_q;
    logic [WIDTH-1:0] rs2_q;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] lo_res;
    logic [WIDTH-1:0] result_q;
    logic             neg_res;
    logic             div_zero;
    logic             div_ovf;
    logic             done_q;

    logic             accept;
    logic             is_div_op;
    logic             sign_a;
    logic             sign_b;
    logic [WIDTH-1:0] rs_hi;
    logic [WIDTH-1:0] fix_src;
    logic [WIDTH-1:0] final_res;
    logic             carry;
    logic             ge;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_ctrl;

    // Operand decode, local compares and the value handed back at the end
    always_comb begin
        accept    = bus.start && !bus.flush;
        is_div_op = op_is_div(op_q);
        sign_a    = op_signed_a(op_q) && rs1_q[WIDTH-1];
        sign_b    = op_signed_b(op_q) && rs2_q[WIDTH-1];
        rs_hi     = {hi[WIDTH-2:0], lo[WIDTH-1]};
        carry     = bus.alu_out < hi;
        ge        = hi[WIDTH-1] | (rs_hi >= opnd);
        fix_src   = ((op_q == MDU_REM) || (op_q == MDU_REMU)) ? hi : lo;
        final_res = lo_res;
        case (op_q)
            MDU_MULH, MDU_MULHSU, MDU_MULHU: final_res = hi;
            MDU_DIV, MDU_DIVU: begin
                if (div_zero)     final_res = '1;
                else if (div_ovf) final_res = MIN_NEG;
            end
            MDU_REM, MDU_REMU: begin
                if (div_zero)     final_res = rs1_q;
                else if (div_ovf) final_res = '0;
            end
            default: final_res = lo_res;
        endcase
    end

    // Next state and the ALU request for the current step
    always_comb begin
        state_next = state;
        alu_a      = '0;
        alu_b      = '0;
        alu_ctrl   = ALU_ADD;
        case (state)
            ST_IDLE: begin
                if (accept) state_next = ST_NEG_A;
            end
            ST_NEG_A: begin
                alu_ctrl   = ALU_SUB;
                alu_b      = rs1_q;
                state_next = ST_NEG_B;
            end
            ST_NEG_B: begin
                alu_ctrl   = ALU_SUB;
                alu_b      = rs2_q;
                state_next = ST_ITER;
            end
            ST_ITER: begin
                if (is_div_op) begin
                    alu_ctrl = ALU_SUB;
                    alu_a    = rs_hi;
                end else begin
                    alu_ctrl = ALU_ADD;
                    alu_a    = hi;
                end
                alu_b = opnd;
                if (cnt == LAST_ITER) state_next = ST_FIX_LO;
            end
            ST_FIX_LO: begin
                alu_ctrl   = ALU_SUB;
                alu_b      = fix_src;
                state_next = ST_FIX_HI;
            end
            ST_FIX_HI: begin
                alu_ctrl   = ALU_ADD;
                alu_a      = ~hi;
                alu_b      = {{(WIDTH-1){1'b0}}, (lo == '0)};
                state_next = ST_DONE;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        if (bus.flush && (state != ST_IDLE)) state_next = ST_IDLE;
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Datapath: operand capture, magnitude, iterate, sign fix, publish result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            op_q     <= MDU_MUL;
            rs1_q    <= '0;
            rs2_q    <= '0;
            hi       <= '0;
            lo       <= '0;
            opnd     <= '0;
            lo_res   <= '0;
            result_q <= '0;
            neg_res  <= 1'b0;
            div_zero <= 1'b0;
            div_ovf  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q  <= mdu_op_e'(bus.op);
                        rs1_q <= bus.rs1;
                        rs2_q <= bus.rs2;
                    end
                end
                ST_NEG_A: begin
                    hi       <= '0;
                    cnt      <= '0;
                    div_zero <= (rs2_q == '0);
                    div_ovf  <= ((op_q == MDU_DIV) || (op_q == MDU_REM)) &&
                                (rs1_q == MIN_NEG) && (rs2_q == '1);
                    neg_res  <= (op_q == MDU_REM) ? sign_a : (sign_a ^ sign_b);
                    if (is_div_op) lo   <= sign_a ? bus.alu_out : rs1_q;
                    else           opnd <= sign_a ? bus.alu_out : rs1_q;
                end
                ST_NEG_B: begin
                    if (is_div_op) opnd <= sign_b ? bus.alu_out : rs2_q;
                    else           lo   <= sign_b ? bus.alu_out : rs2_q;
                end
                ST_ITER: begin
                    cnt <= cnt + 1'b1;
                    if (is_div_op) begin
                        hi <= ge ? bus.alu_out : rs_hi;
                        lo <= {lo[WIDTH-2:0], ge};
                    end else if (lo[0]) begin
                        hi <= {carry, bus.alu_out[WIDTH-1:1]};
                        lo <= {bus.alu_out[0], lo[WIDTH-1:1]};
                    end else begin
                        hi <= {1'b0, hi[WIDTH-1:1]};
                        lo <= {hi[0], lo[WIDTH-1:1]};
                    end
                end
                ST_FIX_LO: begin
                    lo_res <= neg_res ? bus.alu_out : fix_src;
                end
                ST_FIX_HI: begin
                    if (!is_div_op && neg_res) hi <= bus.alu_out;
                end
                ST_DONE: begin
                    if (!bus.flush) begin
                        result_q <= final_res;
                        done_q   <= 1'b1;
                    end
                end
                default: done_q <= 1'b0;
            endcase
        end
    end

    assign bus.busy     = (state != ST_IDLE);
    assign bus.alu_sel  = (state != ST_IDLE);
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.alu_a    = alu_a;
    assign bus.alu_b    = alu_b;
    assign bus.alu_ctrl = alu_ctrl;

endmodule
